// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone classic arbiter.
// Round-robin grant held for the whole of CYC, combinational slave mux,
// broadcast read data and an ack-timeout watchdog that answers a stalled
// master with a one-cycle ERR pulse.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // master 0
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    // grant status
    output logic [1:0]      gnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    logic [1:0]    state_reg, state_next;
    logic          last_reg, last_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic [1:0]    cyc_vec;
    logic [1:0]    ack_vec;
    logic [1:0]    err_vec;
    logic          timeout_hit;

    assign cyc_vec = {m1_cyc_i, m0_cyc_i};

    // Grant status is a pure decode of the state, so reset clears it at once.
    assign gnt_o = {state_reg == GNT1, state_reg == GNT0};

    // Arbitration: round-robin on ties from IDLE, hold while the owner keeps CYC,
    // direct handover to a waiting master when the owner lets go.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (&cyc_vec)
                    state_next = last_reg ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_next = GNT0;
                else if (m1_cyc_i)
                    state_next = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i)
                    state_next = m1_cyc_i ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i)
                    state_next = m0_cyc_i ? GNT0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember which master was granted most recently for the next tie.
    always_comb begin
        last_next = last_reg;
        if (state_next == GNT0)
            last_next = 1'b0;
        else if (state_next == GNT1)
            last_next = 1'b1;
    end

    // Route the granted master to the slave; STB is qualified by CYC so a
    // falling CYC drops the strobe in the same cycle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        case (state_reg)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_cyc_i & m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_cyc_i & m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end
            default: ;
        endcase
    end

    // Ack always wins over a coinciding timeout.
    assign timeout_hit = s_stb_o & ~s_ack_i & (cnt_reg == TIMEOUT_CNT);

    // Watchdog counts unacknowledged strobe cycles of the current grant and
    // restarts after every ack, idle strobe, grant change or emitted ERR.
    always_comb begin
        if ((state_next != state_reg) || !s_stb_o || s_ack_i || timeout_hit)
            cnt_next = '0;
        else
            cnt_next = cnt_reg + TW'(1);
    end

    // Per-master termination: only the granted master ever sees ack or err.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_term
            assign ack_vec[gi] = s_ack_i & gnt_o[gi];
            assign err_vec[gi] = gnt_o[gi] & timeout_hit;
        end
    endgenerate

    assign m0_ack_o = ack_vec[0];
    assign m1_ack_o = ack_vec[1];
    assign m0_err_o = err_vec[0];
    assign m1_err_o = err_vec[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State registers; reset is asynchronous so an in-flight cycle aborts immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// Testbench for wb_arb2: directed scenarios followed by a randomized phase,
// all checked each cycle against a behavioural model of the arbiter rules.
module tb_wb_arb2;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
    localparam int TW      = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;

    // Model: holder 0 = nobody, 1 = m0, 2 = m1; last_m = last granted index;
    // wd = consecutive unacknowledged strobe edges of the current grant.
    int holder;
    int last_m;
    int wd;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_cyc_i (cyc[0]),
        .m0_stb_i (stb[0]),
        .m0_we_i  (we[0]),
        .m0_adr_i (adr[0]),
        .m0_dat_i (dat[0]),
        .m0_sel_i (sel[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (cyc[1]),
        .m1_stb_i (stb[1]),
        .m1_we_i  (we[1]),
        .m1_adr_i (adr[1]),
        .m1_dat_i (dat[1]),
        .m1_sel_i (sel[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        holder = 0;
        last_m = 1;
        wd     = 0;
    endtask

    function automatic logic model_stb();
        if (holder == 0)
            return 1'b0;
        return cyc[holder-1] & stb[holder-1];
    endfunction

    // Compare every DUT output against what the model expects right now.
    task automatic model_check();
        logic        e_cyc, e_stb, e_we;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic [1:0]  e_gnt, e_ack, e_err;
        int          n;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_gnt = 2'b00;
        if (holder != 0) begin
            n = holder - 1;
            e_gnt[n] = 1'b1;
            e_cyc = cyc[n];
            e_stb = cyc[n] & stb[n];
            e_we  = we[n];
            e_adr = adr[n];
            e_dat = dat[n];
            e_sel = sel[n];
        end
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = s_ack & (holder == i + 1);
            e_err[i] = (holder == i + 1) & e_stb & ~s_ack & (wd == TIMEOUT);
        end
        check("gnt",    64'(gnt_o),    64'(e_gnt));
        check("s_cyc",  64'(s_cyc_o),  64'(e_cyc));
        check("s_stb",  64'(s_stb_o),  64'(e_stb));
        check("s_we",   64'(s_we_o),   64'(e_we));
        check("s_adr",  64'(s_adr_o),  64'(e_adr));
        check("s_dat",  64'(s_dat_o),  64'(e_dat));
        check("s_sel",  64'(s_sel_o),  64'(e_sel));
        check("m0_ack", 64'(m0_ack_o), 64'(e_ack[0]));
        check("m1_ack", 64'(m1_ack_o), 64'(e_ack[1]));
        check("m0_err", 64'(m0_err_o), 64'(e_err[0]));
        check("m1_err", 64'(m1_err_o), 64'(e_err[1]));
        check("m0_dat", 64'(m0_dat_o), 64'(s_dat));
        check("m1_dat", 64'(m1_dat_o), 64'(s_dat));
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_tick();
        int   nh;
        logic stb_now;
        stb_now = model_stb();
        if (holder == 0) begin
            if (cyc[0] && cyc[1])
                nh = (last_m == 1) ? 1 : 2;
            else if (cyc[0])
                nh = 1;
            else if (cyc[1])
                nh = 2;
            else
                nh = 0;
        end else if (cyc[holder-1]) begin
            nh = holder;
        end else if (cyc[2-holder]) begin
            nh = 3 - holder;
        end else begin
            nh = 0;
        end
        if (nh != holder)
            wd = 0;
        else if (stb_now && !s_ack && wd < TIMEOUT)
            wd = wd + 1;
        else
            wd = 0;
        if (nh != 0)
            last_m = nh - 1;
        holder = nh;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        model_check();
        @(posedge clk);
        if (rst)
            model_reset();
        else
            model_tick();
        @(negedge clk);
    endtask

    task automatic idle_all();
        cyc = 2'b00;
        stb = 2'b00;
        we  = 2'b00;
        s_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0;
            dat[i] = '0;
            sel[i] = '0;
        end
        s_dat = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check("rst_gnt", 64'(gnt_o), 64'h0);
        check("rst_scyc", 64'(s_cyc_o), 64'h0);
        cycle();
        rst = 1'b0;
        $display("txn reset: released");

        // m0 single read at 0x100
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h100; sel[0] = 4'hF;
        cycle();
        #1;
        check("t1_gnt", 64'(gnt_o), 64'h1);
        check("t1_adr", 64'(s_adr_o), 64'h100);
        cycle();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        #1;
        check("t1_m0ack", 64'(m0_ack_o), 64'h1);
        check("t1_m1ack", 64'(m1_ack_o), 64'h0);
        check("t1_m0dat", 64'(m0_dat_o), 64'hDEAD_BEEF);
        cycle();
        idle_all();
        cycle();
        $display("txn m0 read adr=0x100 data=0x%08h", s_dat);

        // Tie after reset goes to m0, handover without idle, repeat tie to m0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cyc = 2'b11; stb = 2'b11; adr[1] = 32'h180;
        cycle();
        #1;
        check("t2_tie_gnt", 64'(gnt_o), 64'h1);
        s_ack = 1'b1;
        cycle();
        cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
        #1;
        check("t2_drop_scyc", 64'(s_cyc_o), 64'h0);
        cycle();
        #1;
        check("t2_hand_gnt", 64'(gnt_o), 64'h2);
        s_ack = 1'b1;
        cycle();
        cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
        cycle();
        #1;
        check("t2_idle_gnt", 64'(gnt_o), 64'h0);
        cyc = 2'b11; stb = 2'b11;
        cycle();
        #1;
        check("t2_retie_gnt", 64'(gnt_o), 64'h1);
        idle_all();
        cycle();
        $display("txn tie arbitration: m0 then m1 then m0");

        // m1 burst of 4 writes while m0 waits
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        adr[1] = 32'h200; dat[1] = 32'hA5A5_0001;
        cycle();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            dat[1] = 32'hA5A5_0000 + 32'(k);
            adr[1] = 32'h200 + 32'(4 * k);
            s_ack = 1'b1;
            #1;
            check("t3_gnt", 64'(gnt_o), 64'h2);
            check("t3_sdat", 64'(s_dat_o), 64'(32'hA5A5_0000 + 32'(k)));
            cycle();
            $display("txn m1 write %0d data=0x%08h", k, dat[1]);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0; s_ack = 1'b0;
        cycle();
        #1;
        check("t3_m0_after", 64'(gnt_o), 64'h1);
        idle_all();
        cycle();

        // Watchdog: slave never acks m0
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h300;
        cycle();
        for (int c = 0; c <= 5; c++) begin
            #1;
            check("t4_m0err", 64'(m0_err_o), 64'(c == 4));
            check("t4_m1err", 64'(m1_err_o), 64'h0);
            cycle();
        end
        idle_all();
        cycle();
        $display("txn m0 timeout: err in cycle %0d", TIMEOUT);

        // Ack coinciding with timeout wins
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        for (int c = 0; c <= 4; c++) begin
            s_ack = (c == 4);
            #1;
            if (c == 4) begin
                check("t5_m0ack", 64'(m0_ack_o), 64'h1);
                check("t5_m0err", 64'(m0_err_o), 64'h0);
            end
            cycle();
        end
        idle_all();
        cycle();
        $display("txn m0 late ack: ack wins over timeout");

        // Asynchronous reset mid m1 transfer
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h400;
        cycle();
        s_ack = 1'b1;
        #1;
        check("t6_pre_ack", 64'(m1_ack_o), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_scyc", 64'(s_cyc_o), 64'h0);
        check("t6_sstb", 64'(s_stb_o), 64'h0);
        check("t6_gnt", 64'(gnt_o), 64'h0);
        check("t6_m1ack", 64'(m1_ack_o), 64'h0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        cyc = 2'b11; stb = 2'b11; s_ack = 1'b0;
        cycle();
        #1;
        check("t6_tie_gnt", 64'(gnt_o), 64'h1);
        idle_all();
        cycle();
        $display("txn async reset mid m1 transfer, then tie to m0");

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cyc[i] = ~cyc[i];
                stb[i] = ($urandom_range(0, 9) < 7);
                we[i]  = $urandom_range(0, 1) == 1;
                adr[i] = $urandom();
                dat[i] = $urandom();
                sel[i] = 4'($urandom());
            end
            s_dat = $urandom();
            s_ack = ($urandom_range(0, 9) < 3);
            cycle();
        end
        $display("txn random: 600 cycles");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
